// File: rtl/fifo_write_arbiter.sv
// Write-side scheduler for the asynchronous FIFO.
// Shares the single FIFO write port among NUM_REQ requesters using round-robin
// grants with bounded bursts and w_full back-pressure. Each grant costs one
// arbitration cycle in IDLE before the burst starts.
// Optional per-requester ack statistics are built when FIFO_ARB_STATS_EN is
// defined; otherwise stat_count is tied to zero.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned REQ_INDEX_SIZE = 2,
    parameter int unsigned MEMORY_WIDTH   = 8,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                            w_clk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data,
    input  logic                            w_full,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            w_en,
    output logic [MEMORY_WIDTH-1:0]         wdata,
    output logic [REQ_INDEX_SIZE-1:0]       owner,
    output logic                            busy,
    input  logic [REQ_INDEX_SIZE-1:0]       stat_sel,
    output logic [15:0]                     stat_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [REQ_INDEX_SIZE-1:0] LAST_IDX  = REQ_INDEX_SIZE'(NUM_REQ - 1);
    localparam logic [7:0]                LAST_BEAT = 8'(MAX_BURST - 1);

    logic [0:0]                state_q, state_d;
    logic [REQ_INDEX_SIZE-1:0] owner_q, owner_d;
    logic [REQ_INDEX_SIZE-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]                burst_cnt_q, burst_cnt_d;

    logic                      sel_found;
    logic [REQ_INDEX_SIZE-1:0] sel_idx;
    logic [REQ_INDEX_SIZE-1:0] scan_idx;
    logic                      accept;

    logic [MEMORY_WIDTH-1:0]   slice [NUM_REQ];

    // Increment modulo NUM_REQ, so non-power-of-two counts wrap to 0.
    function automatic logic [REQ_INDEX_SIZE-1:0] wrap_inc(input logic [REQ_INDEX_SIZE-1:0] v);
        if (v == LAST_IDX) begin
            return '0;
        end
        return v + REQ_INDEX_SIZE'(1);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*MEMORY_WIDTH +: MEMORY_WIDTH];
    end

    // Round-robin scan: first set req bit starting at rr_ptr and wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // Write-port outputs; wdata always follows the current owner's slice.
    always_comb begin
        accept       = (state_q == ST_BURST) && req[owner_q] && !w_full;
        ack          = '0;
        ack[owner_q] = accept;
        w_en         = accept;
        wdata        = slice[owner_q];
        owner        = owner_q;
        busy         = (state_q == ST_BURST);
    end

    // Next-state logic for grant, burst length and fairness pointer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    owner_d     = sel_idx;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!req[owner_q]) begin
                    // Owner withdrew: release without writing.
                    state_d  = ST_IDLE;
                    rr_ptr_d = wrap_inc(owner_q);
                end else if (!w_full) begin
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_inc(owner_q);
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
                // w_full with req held: stall with everything frozen.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any burst.
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stat_flat;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [15:0] cnt_q;

        // Saturating per-requester ack counter.
        always_ff @(posedge w_clk) begin
            if (wrst) begin
                cnt_q <= '0;
            end else if (ack[g] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign stat_flat[g*16 +: 16] = cnt_q;
    end

    // Selected counter readout; out-of-range selects read as zero.
    always_comb begin
        stat_count = '0;
        if ({1'b0, stat_sel} < (REQ_INDEX_SIZE + 1)'(NUM_REQ)) begin
            stat_count = stat_flat[{stat_sel, 4'b0000} +: 16];
        end
    end
`else
    logic unused_stat_sel;

    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a transaction-level model predicts
// each cycle's outputs and the stream of written words; a monitor compares.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MW = 8;
    localparam int MB = 4;

    logic            w_clk = 1'b0;
    logic            wrst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*MW-1:0] req_data = '0;
    logic            w_full = 1'b0;
    logic [IW-1:0]   stat_sel = '0;
    logic [N-1:0]    ack;
    logic            w_en;
    logic [MW-1:0]   wdata;
    logic [IW-1:0]   owner;
    logic            busy;
    logic [15:0]     stat_count;

    fifo_write_arbiter #(
        .NUM_REQ(N), .REQ_INDEX_SIZE(IW), .MEMORY_WIDTH(MW), .MAX_BURST(MB)
    ) dut (
        .w_clk(w_clk), .wrst(wrst), .req(req), .req_data(req_data), .w_full(w_full),
        .ack(ack), .w_en(w_en), .wdata(wdata), .owner(owner), .busy(busy),
        .stat_sel(stat_sel), .stat_count(stat_count)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        int            cyc;
        logic          w_en;
        logic [N-1:0]  ack;
        logic          busy;
        logic [IW-1:0] owner;
        logic [15:0]   stat;
    } st_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [MW-1:0] data;
    } wr_t;

    st_t sq[$];
    wr_t wq[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: who holds the grant, words written in it, who is first in line.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_done  = 0;
    int m_cnt[N];

    function automatic void chk(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endfunction

    function automatic void release_grant();
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
    endfunction

    // Predict this cycle's outputs from current inputs, then advance the model.
    function automatic void model_cycle();
        st_t          s;
        wr_t          w;
        logic [N-1:0] a;
        a       = '0;
        s.cyc   = cyc;
        s.owner = IW'(m_owner);
        s.busy  = m_busy;
        s.w_en  = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        s.stat = 16'(m_cnt[stat_sel]);
`else
        s.stat = 16'h0;
`endif
        if (m_busy) begin
            if (req[m_owner] && !w_full) begin
                s.w_en     = 1'b1;
                a[m_owner] = 1'b1;
                w.cyc      = cyc;
                w.idx      = m_owner;
                w.data     = req_data[m_owner*MW +: MW];
                wq.push_back(w);
                m_done++;
                if (m_cnt[m_owner] < 16'hFFFF) m_cnt[m_owner]++;
                if (m_done == MB) release_grant();
            end else if (!req[m_owner]) begin
                release_grant();
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_done  = 0;
                    m_busy  = 1;
                    break;
                end
            end
        end
        s.ack = a;
        sq.push_back(s);
        if (wrst) begin
            m_busy  = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_done  = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end
        cyc++;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic f, input logic rs,
                        input logic [N*MW-1:0] d);
        @(posedge w_clk);
        #1;
        req      = r;
        w_full   = f;
        wrst     = rs;
        req_data = d;
        stat_sel = IW'($urandom_range(0, N - 1));
        model_cycle();
    endtask

    // Monitor: pops expectations and compares at the falling edge.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge w_clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("w_en", s.cyc, 32'(w_en), 32'(s.w_en));
                chk("ack", s.cyc, 32'(ack), 32'(s.ack));
                chk("busy", s.cyc, 32'(busy), 32'(s.busy));
                chk("owner", s.cyc, 32'(owner), 32'(s.owner));
                chk("stat_count", s.cyc, 32'(stat_count), 32'(s.stat));
                if (w_en === 1'b1) begin
                    if (wq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write cycle %0d: got w_en 1 expected no write",
                                 s.cyc);
                    end else begin
                        w = wq.pop_front();
                        chk("write_cycle", s.cyc, 32'(s.cyc), 32'(w.cyc));
                        chk("write_owner", s.cyc, 32'(owner), 32'(w.idx));
                        chk("wdata", s.cyc, 32'(wdata), 32'(w.data));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]    r;
        logic [N*MW-1:0] d;
        int              guard;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        repeat (2) @(posedge w_clk);

        // Reset held, then idle with no requests.
        step(4'b0000, 1'b0, 1'b1, '0);
        repeat (10) step(4'b0000, 1'b0, 1'b0, 32'($urandom()));

        // Single requester 1 with fixed data: bursts of MB with a bubble between.
        repeat (12) step(4'b0010, 1'b0, 1'b0, 32'h0000_A500);

        // All requesting: rotation 0,1,2,3,0 after a reset.
        step(4'b0000, 1'b0, 1'b1, '0);
        repeat (25) step(4'b1111, 1'b0, 1'b0, 32'($urandom()));

        // Requester 2 alone, w_full during burst cycles 2-5.
        step(4'b0000, 1'b0, 1'b1, '0);
        for (int i = 0; i < 12; i++) begin
            step(4'b0100, (i >= 2 && i <= 5), 1'b0, 32'($urandom()));
        end

        // Requester 0 drops after its 2nd ack; pending requester 3 is next.
        step(4'b0000, 1'b0, 1'b1, '0);
        guard = 0;
        do begin
            step(4'b1001, 1'b0, 1'b0, 32'($urandom()));
            guard++;
        end while (!(m_busy && m_owner == 0 && m_done == 2) && guard < 10);
        repeat (8) step(4'b1000, 1'b0, 1'b0, 32'($urandom()));

        // Randomised traffic with back-pressure, drops and occasional resets.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            d = 32'($urandom());
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0), d);
        end

        step(4'b0000, 1'b0, 1'b0, '0);
        repeat (2) @(posedge w_clk);
        #1;
        chk("status_queue_drained", cyc, 32'(sq.size()), 32'd0);
        chk("write_queue_drained", cyc, 32'(wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
